// File: rtl/regfile_port_ctrl_if.sv
// Register-file port sharing bus: pipeline writeback, decode read, debug req/ack
// and the register-file facing write port / read port A.
interface regfile_port_ctrl_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              wbEn_I;
    logic [ADDR_W-1:0] wbAddr_I;
    logic [XLEN-1:0]   wbData_I;
    logic [ADDR_W-1:0] pipeAddrA_I;
    logic              pipeREn_I;
    logic              dbgReq_I;
    logic              dbgWe_I;
    logic [ADDR_W-1:0] dbgAddr_I;
    logic [XLEN-1:0]   dbgWData_I;
    logic [XLEN-1:0]   rfDataA_I;
    logic              dbgAck_O;
    logic [XLEN-1:0]   dbgRData_O;
    logic              rfWEn_O;
    logic [ADDR_W-1:0] rfDest_O;
    logic [XLEN-1:0]   rfWData_O;
    logic [ADDR_W-1:0] rfAddrA_O;
    logic              rfREn_O;
    logic              stall_O;
    logic              clearDone_O;

    // Environment side: pipeline, debug host and register file model
    modport master (
        output wbEn_I, wbAddr_I, wbData_I, pipeAddrA_I, pipeREn_I,
        output dbgReq_I, dbgWe_I, dbgAddr_I, dbgWData_I, rfDataA_I,
        input  dbgAck_O, dbgRData_O, rfWEn_O, rfDest_O, rfWData_O,
        input  rfAddrA_O, rfREn_O, stall_O, clearDone_O
    );

    // Controller side
    modport slave (
        input  wbEn_I, wbAddr_I, wbData_I, pipeAddrA_I, pipeREn_I,
        input  dbgReq_I, dbgWe_I, dbgAddr_I, dbgWData_I, rfDataA_I,
        output dbgAck_O, dbgRData_O, rfWEn_O, rfDest_O, rfWData_O,
        output rfAddrA_O, rfREn_O, stall_O, clearDone_O
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register file write-port / read-port-A sequencer: post-reset clear of x1..x31,
// pipeline writeback pass-through, and a four-phase debug port that borrows the ports.
module regfile_port_ctrl #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                clk_I,
    input  logic                rst_n_I,
    regfile_port_ctrl_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        IDLE   = 3'd1,
        DBG_WR = 3'd2,
        DBG_RD = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic              clear_done_q, clear_done_d;

    logic              wen_c;
    logic [ADDR_W-1:0] dest_c;
    logic [XLEN-1:0]   wdata_c;
    logic [ADDR_W-1:0] addr_a_c;
    logic              ren_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        dbg_rdata_d  = dbg_rdata_q;
        clear_done_d = clear_done_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_REG) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (bus.dbgReq_I) begin
                    state_d = bus.dbgWe_I ? DBG_WR : DBG_RD;
                end
            end
            DBG_WR: begin
                // Pipeline writeback owns the port; retry until it is free
                if (!bus.wbEn_I) begin
                    state_d = DONE;
                end
            end
            DBG_RD: begin
                dbg_rdata_d = bus.rfDataA_I;
                state_d     = DONE;
            end
            DONE: begin
                if (!bus.dbgReq_I) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
        dbg_ack_d = (state_d == DONE);
    end

    // Write-port mux: clear first, then pipeline, then debug write
    always_comb begin
        wen_c   = 1'b0;
        dest_c  = bus.wbAddr_I;
        wdata_c = bus.wbData_I;
        if (state_q == CLEAR) begin
            wen_c   = 1'b1;
            dest_c  = clr_cnt_q;
            wdata_c = '0;
        end else if (bus.wbEn_I) begin
            wen_c = |bus.wbAddr_I;
        end else if (state_q == DBG_WR) begin
            wen_c   = |bus.dbgAddr_I;
            dest_c  = bus.dbgAddr_I;
            wdata_c = bus.dbgWData_I;
        end
    end

    // Read port A is borrowed only during the single debug-read cycle
    always_comb begin
        addr_a_c = bus.pipeAddrA_I;
        ren_c    = bus.pipeREn_I;
        if (state_q == DBG_RD) begin
            addr_a_c = bus.dbgAddr_I;
            ren_c    = 1'b1;
        end
    end

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= ADDR_W'(1);
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_rdata_q  <= dbg_rdata_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign bus.rfWEn_O     = wen_c & rst_n_I;
    assign bus.rfDest_O    = dest_c;
    assign bus.rfWData_O   = wdata_c;
    assign bus.rfAddrA_O   = addr_a_c;
    assign bus.rfREn_O     = ren_c;
    assign bus.stall_O     = (state_q == CLEAR) || (state_q == DBG_RD);
    assign bus.dbgAck_O    = dbg_ack_q;
    assign bus.dbgRData_O  = dbg_rdata_q;
    assign bus.clearDone_O = clear_done_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a small register-file model on the ports.
module tb_regfile_port_ctrl;
    logic clk_I   = 1'b0;
    logic rst_n_I = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    regfile_port_ctrl_if #(.XLEN(32), .ADDR_W(5)) bus ();

    regfile_port_ctrl #(.NREG(32), .XLEN(32), .ADDR_W(5)) dut (
        .clk_I   (clk_I),
        .rst_n_I (rst_n_I),
        .bus     (bus)
    );

    always #5 clk_I = ~clk_I;

    // Register file model: synchronous write, combinational read port A
    logic [31:0] rf_mem [32];
    always @(posedge clk_I) begin
        if (bus.rfWEn_O) rf_mem[bus.rfDest_O] <= bus.rfWData_O;
    end
    assign bus.rfDataA_I = (bus.rfAddrA_O == 5'd0) ? 32'd0 : rf_mem[bus.rfAddrA_O];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Release reset and check the full 31-cycle clear, with writeback asserted to show it is ignored
    task automatic run_clear();
        bus.wbEn_I   = 1'b1;
        bus.wbAddr_I = 5'd4;
        bus.wbData_I = 32'hBAD0_BAD0;
        @(negedge clk_I);
        rst_n_I = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            if (i > 1) @(negedge clk_I);
            #1;
            chk($sformatf("clr_wen_%0d", i), 32'(bus.rfWEn_O), 32'd1);
            chk($sformatf("clr_dest_%0d", i), 32'(bus.rfDest_O), 32'(i));
            chk($sformatf("clr_data_%0d", i), bus.rfWData_O, 32'd0);
            chk($sformatf("clr_stall_%0d", i), 32'(bus.stall_O), 32'd1);
            chk($sformatf("clr_done_lo_%0d", i), 32'(bus.clearDone_O), 32'd0);
        end
        @(negedge clk_I);
        bus.wbEn_I = 1'b0;
        #1;
        chk("clr_done_hi", 32'(bus.clearDone_O), 32'd1);
        chk("clr_stall_lo", 32'(bus.stall_O), 32'd0);
        chk("clr_idle_wen", 32'(bus.rfWEn_O), 32'd0);
    endtask

    initial begin
        bus.wbEn_I      = 1'b1;
        bus.wbAddr_I    = 5'd4;
        bus.wbData_I    = 32'hBAD0_BAD0;
        bus.pipeAddrA_I = 5'd2;
        bus.pipeREn_I   = 1'b1;
        bus.dbgReq_I    = 1'b0;
        bus.dbgWe_I     = 1'b0;
        bus.dbgAddr_I   = 5'd0;
        bus.dbgWData_I  = 32'd0;

        // Reset state
        repeat (2) @(negedge clk_I);
        #1;
        chk("rst_wen", 32'(bus.rfWEn_O), 32'd0);
        chk("rst_stall", 32'(bus.stall_O), 32'd1);
        chk("rst_ack", 32'(bus.dbgAck_O), 32'd0);
        chk("rst_rdata", bus.dbgRData_O, 32'd0);
        chk("rst_done", 32'(bus.clearDone_O), 32'd0);

        run_clear();

        // Debug write x5, no contention
        @(negedge clk_I);
        bus.dbgReq_I = 1'b1; bus.dbgWe_I = 1'b1;
        bus.dbgAddr_I = 5'd5; bus.dbgWData_I = 32'h00AB_CDEF;
        #1;
        chk("w5_idle_wen", 32'(bus.rfWEn_O), 32'd0);
        @(negedge clk_I); #1;
        chk("w5_wen", 32'(bus.rfWEn_O), 32'd1);
        chk("w5_dest", 32'(bus.rfDest_O), 32'd5);
        chk("w5_data", bus.rfWData_O, 32'h00AB_CDEF);
        chk("w5_ack_lo", 32'(bus.dbgAck_O), 32'd0);
        chk("w5_stall", 32'(bus.stall_O), 32'd0);
        @(negedge clk_I); #1;
        chk("w5_ack_hi", 32'(bus.dbgAck_O), 32'd1);
        chk("w5_done_wen", 32'(bus.rfWEn_O), 32'd0);
        bus.dbgReq_I = 1'b0;
        @(negedge clk_I); #1;
        chk("w5_ack_drop", 32'(bus.dbgAck_O), 32'd0);

        // Debug write x7 blocked by three pipeline writebacks to x3
        @(negedge clk_I);
        bus.dbgReq_I = 1'b1; bus.dbgWe_I = 1'b1;
        bus.dbgAddr_I = 5'd7; bus.dbgWData_I = 32'h7777_0007;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_I);
            bus.wbEn_I = 1'b1; bus.wbAddr_I = 5'd3; bus.wbData_I = 32'h3330 + 32'(i);
            #1;
            chk($sformatf("w7_wb_dest_%0d", i), 32'(bus.rfDest_O), 32'd3);
            chk($sformatf("w7_wb_data_%0d", i), bus.rfWData_O, 32'h3330 + 32'(i));
            chk($sformatf("w7_ack_lo_%0d", i), 32'(bus.dbgAck_O), 32'd0);
        end
        @(negedge clk_I);
        bus.wbEn_I = 1'b0;
        #1;
        chk("w7_wen", 32'(bus.rfWEn_O), 32'd1);
        chk("w7_dest", 32'(bus.rfDest_O), 32'd7);
        chk("w7_data", bus.rfWData_O, 32'h7777_0007);
        chk("w7_ack_lo", 32'(bus.dbgAck_O), 32'd0);
        @(negedge clk_I); #1;
        chk("w7_ack_hi", 32'(bus.dbgAck_O), 32'd1);
        bus.dbgReq_I = 1'b0;
        @(negedge clk_I); #1;
        chk("w7_ack_drop", 32'(bus.dbgAck_O), 32'd0);

        // Pipeline writeback to x9, then to x0 (suppressed)
        @(negedge clk_I);
        bus.wbEn_I = 1'b1; bus.wbAddr_I = 5'd9; bus.wbData_I = 32'h1234_5678;
        #1;
        chk("wb9_wen", 32'(bus.rfWEn_O), 32'd1);
        @(negedge clk_I);
        bus.wbAddr_I = 5'd0; bus.wbData_I = 32'hFFFF_FFFF;
        #1;
        chk("wb0_wen", 32'(bus.rfWEn_O), 32'd0);

        // Debug read x9 with a same-cycle writeback to x9
        @(negedge clk_I);
        bus.wbEn_I = 1'b0;
        bus.dbgReq_I = 1'b1; bus.dbgWe_I = 1'b0; bus.dbgAddr_I = 5'd9;
        #1;
        chk("r9_idle_addr", 32'(bus.rfAddrA_O), 32'd2);
        chk("r9_idle_stall", 32'(bus.stall_O), 32'd0);
        @(negedge clk_I);
        bus.wbEn_I = 1'b1; bus.wbAddr_I = 5'd9; bus.wbData_I = 32'h0000_DEAD;
        #1;
        chk("r9_stall", 32'(bus.stall_O), 32'd1);
        chk("r9_addr", 32'(bus.rfAddrA_O), 32'd9);
        chk("r9_ren", 32'(bus.rfREn_O), 32'd1);
        chk("r9_wb_wen", 32'(bus.rfWEn_O), 32'd1);
        @(negedge clk_I);
        bus.wbEn_I = 1'b0; bus.pipeREn_I = 1'b0;
        #1;
        chk("r9_ack_hi", 32'(bus.dbgAck_O), 32'd1);
        chk("r9_rdata", bus.dbgRData_O, 32'h1234_5678);
        chk("r9_addr_back", 32'(bus.rfAddrA_O), 32'd2);
        chk("r9_ren_back", 32'(bus.rfREn_O), 32'd0);
        chk("r9_stall_lo", 32'(bus.stall_O), 32'd0);
        bus.dbgReq_I = 1'b0;
        @(negedge clk_I); #1;
        chk("r9_ack_drop", 32'(bus.dbgAck_O), 32'd0);
        chk("r9_rdata_hold", bus.dbgRData_O, 32'h1234_5678);

        // Debug write to x0: ack without a write pulse
        @(negedge clk_I);
        bus.dbgReq_I = 1'b1; bus.dbgWe_I = 1'b1;
        bus.dbgAddr_I = 5'd0; bus.dbgWData_I = 32'hCAFE_F00D;
        @(negedge clk_I); #1;
        chk("w0_wen", 32'(bus.rfWEn_O), 32'd0);
        chk("w0_ack_lo", 32'(bus.dbgAck_O), 32'd0);
        @(negedge clk_I); #1;
        chk("w0_ack_hi", 32'(bus.dbgAck_O), 32'd1);
        bus.dbgReq_I = 1'b0;
        @(negedge clk_I); #1;
        chk("w0_ack_drop", 32'(bus.dbgAck_O), 32'd0);

        // Reset asserted during the debug-read stall cycle
        @(negedge clk_I);
        bus.dbgReq_I = 1'b1; bus.dbgWe_I = 1'b0; bus.dbgAddr_I = 5'd9;
        @(negedge clk_I); #1;
        chk("rr_stall", 32'(bus.stall_O), 32'd1);
        #1;
        rst_n_I = 1'b0;
        #1;
        chk("rr_ack", 32'(bus.dbgAck_O), 32'd0);
        chk("rr_rdata", bus.dbgRData_O, 32'd0);
        chk("rr_done", 32'(bus.clearDone_O), 32'd0);
        chk("rr_stall_rst", 32'(bus.stall_O), 32'd1);
        bus.dbgReq_I = 1'b0;
        @(negedge clk_I); #1;
        chk("rr_ack_held", 32'(bus.dbgAck_O), 32'd0);

        // Partial clear, then reset mid-clear
        @(negedge clk_I);
        rst_n_I = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk_I);
            #1;
            chk($sformatf("pc_dest_%0d", i), 32'(bus.rfDest_O), 32'(i));
        end
        #1;
        rst_n_I = 1'b0;
        #1;
        chk("pc_rst_wen", 32'(bus.rfWEn_O), 32'd0);
        chk("pc_rst_stall", 32'(bus.stall_O), 32'd1);

        run_clear();

        // Clear must have zeroed the modelled registers
        chk("post_x9", rf_mem[9], 32'd0);
        chk("post_x5", rf_mem[5], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
